// File: rtl/arm_mem_pkg.sv
// Shared definitions for the multiport ARM memory: fault cause codes and
// the address-region hit test used by the decoder.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_UNMAPPED = 2'd1,
        CAUSE_MISALIGN = 2'd2,
        CAUSE_RO       = 2'd3
    } cause_e;

    // True when addr lies in [base, base + nbytes). Evaluated at 33 bits so a
    // region ending exactly at 2^32 cannot wrap and alias low addresses.
    function automatic logic region_hit(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [32:0] nbytes);
        logic [32:0] a;
        logic [32:0] lo;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        return (a >= lo) && (a < lo + nbytes);
    endfunction

    // Power-of-two test for region depths.
    function automatic logic is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/arm_mem_region.sv
// One storage region: a word array with NPORTS byte-enable write lanes and
// NPORTS registered read lanes. Reads return the pre-write contents of the
// cycle; on a same-byte write collision the lowest port index wins.
module arm_mem_region #(
    parameter int unsigned NPORTS = 2,
    parameter int unsigned WORDS  = 256,
    parameter int unsigned AW     = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                   clk,
    input  logic [NPORTS-1:0]      wr_en,
    input  logic [NPORTS*AW-1:0]   wr_idx,
    input  logic [4*NPORTS-1:0]    wr_be,
    input  logic [32*NPORTS-1:0]   wr_data,
    input  logic [NPORTS-1:0]      rd_en,
    input  logic [NPORTS*AW-1:0]   rd_idx,
    output logic [32*NPORTS-1:0]   rd_data
);

    logic [31:0] mem [WORDS];

    // Storage update and read lanes. Ports are walked from highest to lowest
    // so the lowest index issues the final non-blocking write to a byte and
    // therefore wins; reads sample the array before any of this cycle's writes.
    always_ff @(posedge clk) begin
        for (int p = int'(NPORTS) - 1; p >= 0; p--) begin
            if (wr_en[p]) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_be[4*p + b]) begin
                        mem[wr_idx[AW*p +: AW]][8*b +: 8] <= wr_data[32*p + 8*b +: 8];
                    end
                end
            end
            if (rd_en[p]) begin
                rd_data[32*p +: 32] <= mem[rd_idx[AW*p +: AW]];
            end
        end
    end

endmodule

// File: rtl/arm_mem_multiport.sv
// N-port word memory with separate data and text regions. Decodes each
// port's address, classifies faults, drives two region instances and
// registers a one-cycle response with a cause code per port.
module arm_mem_multiport
    import arm_mem_pkg::*;
#(
    parameter int unsigned NPORTS     = 2,
    parameter logic [31:0] DATA_BASE  = 32'h0000_0000,
    parameter int unsigned DATA_WORDS = 256,
    parameter logic [31:0] TEXT_BASE  = 32'h0010_0000,
    parameter int unsigned TEXT_WORDS = 256,
    parameter bit          TEXT_RO    = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORTS-1:0]      req_valid,
    input  logic [NPORTS-1:0]      req_write,
    input  logic [32*NPORTS-1:0]   req_addr,
    input  logic [4*NPORTS-1:0]    req_be,
    input  logic [32*NPORTS-1:0]   req_wdata,
    output logic [NPORTS-1:0]      rsp_valid,
    output logic [32*NPORTS-1:0]   rsp_rdata,
    output logic [NPORTS-1:0]      rsp_excpt,
    output logic [2*NPORTS-1:0]    rsp_cause,
    output logic                   excpt_sticky,
    input  logic                   excpt_clr
);

    localparam int unsigned DAW        = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam int unsigned TAW        = (TEXT_WORDS > 1) ? $clog2(TEXT_WORDS) : 1;
    localparam logic [32:0] DATA_BYTES = 33'(DATA_WORDS) << 2;
    localparam logic [32:0] TEXT_BYTES = 33'(TEXT_WORDS) << 2;
    localparam logic [63:0] DATA_LO    = 64'(DATA_BASE);
    localparam logic [63:0] DATA_HI    = DATA_LO + 64'(DATA_WORDS) * 64'd4;
    localparam logic [63:0] TEXT_LO    = 64'(TEXT_BASE);
    localparam logic [63:0] TEXT_HI    = TEXT_LO + 64'(TEXT_WORDS) * 64'd4;

    // Reject configurations the decoder cannot serve.
    if (NPORTS < 1 || NPORTS > 4) begin : g_bad_nports
        $error("arm_mem_multiport: NPORTS must be 1..4");
    end
    if (!is_pow2(DATA_WORDS) || !is_pow2(TEXT_WORDS)) begin : g_bad_depth
        $error("arm_mem_multiport: region depths must be powers of two");
    end
    if ((DATA_LO < TEXT_HI) && (TEXT_LO < DATA_HI)) begin : g_overlap
        $error("arm_mem_multiport: data and text regions overlap");
    end

    // Fault classification in priority order: misaligned, unmapped, RO text.
    function automatic cause_e classify(input logic misal, input logic hd,
                                        input logic ht, input logic write);
        if (misal)                   return CAUSE_MISALIGN;
        if (!hd && !ht)              return CAUSE_UNMAPPED;
        if (ht && write && TEXT_RO)  return CAUSE_RO;
        return CAUSE_NONE;
    endfunction

    logic [NPORTS-1:0]      hit_d;
    logic [NPORTS-1:0]      hit_t;
    logic [NPORTS-1:0]      ok;
    logic [NPORTS-1:0]      fault;
    logic [2*NPORTS-1:0]    cause_p0;
    logic [NPORTS-1:0]      d_wr;
    logic [NPORTS-1:0]      d_rd;
    logic [NPORTS-1:0]      t_wr;
    logic [NPORTS-1:0]      t_rd;
    logic [NPORTS*DAW-1:0]  d_idx;
    logic [NPORTS*TAW-1:0]  t_idx;
    logic [32*NPORTS-1:0]   d_rdata;
    logic [32*NPORTS-1:0]   t_rdata;

    logic [NPORTS-1:0]      vld_p1;
    logic [NPORTS-1:0]      sel_d_p1;
    logic [NPORTS-1:0]      sel_t_p1;
    logic [2*NPORTS-1:0]    cause_p1;
    logic                   sticky_p1;

    // ---- request decode (stage p0) ----
    for (genvar p = 0; p < NPORTS; p++) begin : g_dec
        logic [31:0] addr;
        assign addr     = req_addr[32*p +: 32];
        assign hit_d[p] = region_hit(addr, DATA_BASE, DATA_BYTES);
        assign hit_t[p] = region_hit(addr, TEXT_BASE, TEXT_BYTES);

        assign cause_p0[2*p +: 2] = req_valid[p]
                                  ? classify(addr[1:0] != 2'b00, hit_d[p], hit_t[p], req_write[p])
                                  : CAUSE_NONE;
        assign fault[p] = (cause_p0[2*p +: 2] != CAUSE_NONE);
        assign ok[p]    = req_valid[p] && !fault[p];

        assign d_wr[p]  = ok[p] &&  req_write[p] && hit_d[p];
        assign d_rd[p]  = ok[p] && !req_write[p] && hit_d[p];
        assign t_wr[p]  = ok[p] &&  req_write[p] && hit_t[p];
        assign t_rd[p]  = ok[p] && !req_write[p] && hit_t[p];

        assign d_idx[DAW*p +: DAW] = DAW'((addr - DATA_BASE) >> 2);
        assign t_idx[TAW*p +: TAW] = TAW'((addr - TEXT_BASE) >> 2);
    end

    arm_mem_region #(
        .NPORTS (NPORTS),
        .WORDS  (DATA_WORDS),
        .AW     (DAW)
    ) u_data (
        .clk     (clk),
        .wr_en   (d_wr),
        .wr_idx  (d_idx),
        .wr_be   (req_be),
        .wr_data (req_wdata),
        .rd_en   (d_rd),
        .rd_idx  (d_idx),
        .rd_data (d_rdata)
    );

    arm_mem_region #(
        .NPORTS (NPORTS),
        .WORDS  (TEXT_WORDS),
        .AW     (TAW)
    ) u_text (
        .clk     (clk),
        .wr_en   (t_wr),
        .wr_idx  (t_idx),
        .wr_be   (req_be),
        .wr_data (req_wdata),
        .rd_en   (t_rd),
        .rd_idx  (t_idx),
        .rd_data (t_rdata)
    );

    // ---- response registers (stage p1) ----
    // Response control and the sticky fault flag; a new fault beats a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1    <= '0;
            sel_d_p1  <= '0;
            sel_t_p1  <= '0;
            cause_p1  <= '0;
            sticky_p1 <= 1'b0;
        end else begin
            vld_p1   <= req_valid;
            sel_d_p1 <= d_rd;
            sel_t_p1 <= t_rd;
            cause_p1 <= cause_p0;
            if (|fault) begin
                sticky_p1 <= 1'b1;
            end else if (excpt_clr) begin
                sticky_p1 <= 1'b0;
            end
        end
    end

    // Read data is steered from the region that served the read; writes,
    // faults and idle cycles return zero.
    for (genvar p = 0; p < NPORTS; p++) begin : g_rsp
        assign rsp_rdata[32*p +: 32] = sel_d_p1[p] ? d_rdata[32*p +: 32]
                                     : sel_t_p1[p] ? t_rdata[32*p +: 32]
                                     : 32'h0;
        assign rsp_excpt[p] = (cause_p1[2*p +: 2] != CAUSE_NONE);
    end

    assign rsp_valid    = vld_p1;
    assign rsp_cause    = cause_p1;
    assign excpt_sticky = sticky_p1;

endmodule

// File: tb/tb_arm_mem_multiport.sv
// Scoreboard bench for arm_mem_multiport with two ports: expected responses
// are queued per port when a request is driven and compared on response.
module tb_arm_mem_multiport;

    localparam int NP = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NP-1:0]   req_valid = '0;
    logic [NP-1:0]   req_write = '0;
    logic [32*NP-1:0] req_addr = '0;
    logic [4*NP-1:0] req_be = '0;
    logic [32*NP-1:0] req_wdata = '0;
    logic [NP-1:0]   rsp_valid;
    logic [32*NP-1:0] rsp_rdata;
    logic [NP-1:0]   rsp_excpt;
    logic [2*NP-1:0] rsp_cause;
    logic            excpt_sticky;
    logic            excpt_clr = 1'b0;

    arm_mem_multiport #(
        .NPORTS     (NP),
        .DATA_BASE  (32'h0000_0000),
        .DATA_WORDS (256),
        .TEXT_BASE  (32'h0010_0000),
        .TEXT_WORDS (256),
        .TEXT_RO    (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_be       (req_be),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_excpt    (rsp_excpt),
        .rsp_cause    (rsp_cause),
        .excpt_sticky (excpt_sticky),
        .excpt_clr    (excpt_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          due;
        logic        chk;
        logic [31:0] rdata;
        logic        excpt;
        logic [1:0]  cause;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    function automatic int sb_size(input int p);
        return (p == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic void sb_push(input int p, input exp_t e);
        if (p == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endfunction

    function automatic exp_t sb_pop(input int p);
        return (p == 0) ? sb0.pop_front() : sb1.pop_front();
    endfunction

    function automatic int sb_front_due(input int p);
        return (p == 0) ? sb0[0].due : sb1[0].due;
    endfunction

    // Reference memory: data-region words keyed by word address.
    logic [31:0] mdl [int unsigned];

    function automatic logic [1:0] exp_cause(input logic w, input logic [31:0] a);
        logic in_d;
        logic in_t;
        in_d = (a < 32'h0000_0400);
        in_t = (a >= 32'h0010_0000) && (a < 32'h0010_0400);
        if (a[1:0] != 2'b00) return 2'd2;
        if (!in_d && !in_t)  return 2'd1;
        if (in_t && w)       return 2'd3;
        return 2'd0;
    endfunction

    logic        st_v   [NP];
    logic        st_w   [NP];
    logic [31:0] st_a   [NP];
    logic [3:0]  st_be  [NP];
    logic [31:0] st_d   [NP];
    logic        st_clr;

    task automatic clear_stage();
        for (int p = 0; p < NP; p++) begin
            st_v[p] = 1'b0; st_w[p] = 1'b0; st_a[p] = '0; st_be[p] = '0; st_d[p] = '0;
        end
        st_clr = 1'b0;
    endtask

    task automatic stage(input int p, input logic w, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] d);
        st_v[p] = 1'b1; st_w[p] = w; st_a[p] = a; st_be[p] = be; st_d[p] = d;
    endtask

    // Drive the staged requests for one cycle and queue their expectations.
    task automatic commit();
        exp_t        e;
        logic [1:0]  c;
        logic [31:0] word;
        int unsigned k;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            req_valid[p]           = st_v[p];
            req_write[p]           = st_w[p];
            req_addr[32*p +: 32]   = st_a[p];
            req_be[4*p +: 4]       = st_be[p];
            req_wdata[32*p +: 32]  = st_d[p];
        end
        excpt_clr = st_clr;
        for (int p = 0; p < NP; p++) begin
            if (st_v[p]) begin
                c       = exp_cause(st_w[p], st_a[p]);
                e.due   = cyc + 1;
                e.cause = c;
                e.excpt = (c != 2'd0);
                e.rdata = 32'h0;
                e.chk   = 1'b1;
                if (c == 2'd0 && !st_w[p]) begin
                    k = st_a[p] >> 2;
                    if (st_a[p] < 32'h400 && mdl.exists(k)) e.rdata = mdl[k];
                    else                                    e.chk   = 1'b0;
                end
                sb_push(p, e);
            end
        end
        for (int p = NP - 1; p >= 0; p--) begin
            if (st_v[p] && st_w[p] && exp_cause(st_w[p], st_a[p]) == 2'd0 && st_a[p] < 32'h400) begin
                k    = st_a[p] >> 2;
                word = mdl.exists(k) ? mdl[k] : 32'h0;
                for (int b = 0; b < 4; b++) begin
                    if (st_be[p][b]) word[8*b +: 8] = st_d[p][8*b +: 8];
                end
                mdl[k] = word;
            end
        end
        clear_stage();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) commit();
    endtask

    task automatic monitor_port(input int p);
        exp_t e;
        if (rsp_valid[p]) begin
            if (sb_size(p) == 0) begin
                check($sformatf("p%0d_unexpected_rsp", p), 32'd1, 32'd0);
            end else begin
                e = sb_pop(p);
                check($sformatf("p%0d_latency", p), cyc, e.due);
                if (e.chk) check($sformatf("p%0d_rdata", p), rsp_rdata[32*p +: 32], e.rdata);
                check($sformatf("p%0d_excpt", p), {31'b0, rsp_excpt[p]}, {31'b0, e.excpt});
                check($sformatf("p%0d_cause", p), {30'b0, rsp_cause[2*p +: 2]}, {30'b0, e.cause});
            end
        end else if (sb_size(p) != 0 && sb_front_due(p) <= cyc) begin
            e = sb_pop(p);
            check($sformatf("p%0d_missing_rsp", p), 32'd0, 32'd1);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int p = 0; p < NP; p++) monitor_port(p);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_stage();
        #2;
        check("rst_valid",  {30'b0, rsp_valid}, 32'd0);
        check("rst_rdata0", rsp_rdata[31:0], 32'd0);
        check("rst_excpt",  {30'b0, rsp_excpt}, 32'd0);
        check("rst_cause",  {28'b0, rsp_cause}, 32'd0);
        check("rst_sticky", {31'b0, excpt_sticky}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Basic write then read.
        stage(0, 1, 32'h10, 4'hF, 32'hDEADBEEF); commit();
        stage(0, 0, 32'h10, 4'hF, 32'h0);        commit();
        idle(2);
        check("no_fault_sticky", {31'b0, excpt_sticky}, 32'd0);

        // Byte-lane merge, and a read with a partial be returns the whole word.
        stage(0, 1, 32'h20, 4'hF,    32'h11223344); commit();
        stage(0, 1, 32'h20, 4'b0101, 32'hAABBCCDD); commit();
        stage(1, 0, 32'h20, 4'b0010, 32'h0);        commit();

        // Same-word full collision: port0 wins.
        stage(0, 1, 32'h40, 4'hF, 32'h00000000);
        stage(1, 1, 32'h40, 4'hF, 32'hFFFFFFFF); commit();
        stage(0, 0, 32'h40, 4'hF, 32'h0);        commit();

        // Cross-port byte merge on one word.
        stage(0, 1, 32'h44, 4'b1100, 32'hA1B2C3D4);
        stage(1, 1, 32'h44, 4'b0110, 32'h55667788); commit();
        stage(1, 1, 32'h44, 4'b0001, 32'h000000EE);
        stage(0, 1, 32'h48, 4'hF,    32'hCAFEF00D); commit();
        stage(0, 0, 32'h44, 4'hF, 32'h0);
        stage(1, 0, 32'h48, 4'hF, 32'h0);           commit();

        // Read-first between ports.
        stage(0, 1, 32'h40, 4'hF, 32'h00000005);
        stage(1, 0, 32'h40, 4'hF, 32'h0);        commit();
        stage(1, 0, 32'h40, 4'hF, 32'h0);        commit();

        // be=0 write is a no-op with a clean response.
        stage(0, 1, 32'h40, 4'h0, 32'h12345678); commit();
        stage(0, 0, 32'h40, 4'hF, 32'h0);        commit();

        // Region edges: last data word, and word 0 not aliased by base+size.
        stage(0, 1, 32'h3FC, 4'hF, 32'h0BADF00D);
        stage(1, 1, 32'h000, 4'hF, 32'h87654321); commit();
        stage(0, 1, 32'h400, 4'hF, 32'hFFFFFFFF); commit();
        stage(0, 0, 32'h3FC, 4'hF, 32'h0);
        stage(1, 0, 32'h000, 4'hF, 32'h0);        commit();
        idle(1);
        check("unmapped_wr_sticky", {31'b0, excpt_sticky}, 32'd1);
        st_clr = 1'b1; commit();
        idle(1);
        check("clr_sticky", {31'b0, excpt_sticky}, 32'd0);

        // Fault causes and priorities.
        stage(0, 0, 32'h3, 4'hF, 32'h0);         commit();
        idle(1);
        check("misalign_sticky", {31'b0, excpt_sticky}, 32'd1);
        st_clr = 1'b1; commit(); idle(1);
        check("clr2_sticky", {31'b0, excpt_sticky}, 32'd0);
        stage(1, 0, 32'h400, 4'hF, 32'h0);       commit();
        stage(0, 0, 32'h401, 4'hF, 32'h0);
        stage(1, 1, 32'h0010_0002, 4'hF, 32'h1); commit();
        stage(0, 1, 32'h0010_0000, 4'hF, 32'h99999999);
        stage(1, 0, 32'h0010_03FC, 4'hF, 32'h0); commit();
        stage(0, 0, 32'h0010_0400, 4'hF, 32'h0); commit();
        idle(1);
        check("ro_sticky", {31'b0, excpt_sticky}, 32'd1);
        st_clr = 1'b1; commit(); idle(1);
        check("clr3_sticky", {31'b0, excpt_sticky}, 32'd0);

        // Clear and a new fault in the same cycle: set wins.
        stage(1, 0, 32'h2, 4'hF, 32'h0); st_clr = 1'b1; commit();
        idle(1);
        check("set_wins_sticky", {31'b0, excpt_sticky}, 32'd1);

        // Asynchronous reset between edges drops the in-flight response.
        stage(0, 0, 32'h5, 4'hF, 32'h0); commit();
        @(posedge clk);
        #2;
        check("prerst_valid", {31'b0, rsp_valid[0]}, 32'd1);
        rst = 1'b0;
        req_valid = '0;
        excpt_clr = 1'b0;
        #1;
        check("async_rst_valid",  {30'b0, rsp_valid}, 32'd0);
        check("async_rst_sticky", {31'b0, excpt_sticky}, 32'd0);
        check("async_rst_cause",  {28'b0, rsp_cause}, 32'd0);
        sb0.delete();
        sb1.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Storage survives reset.
        stage(0, 0, 32'h10, 4'hF, 32'h0);
        stage(1, 0, 32'h44, 4'hF, 32'h0); commit();
        stage(0, 0, 32'h40, 4'hF, 32'h0); commit();
        idle(3);
        check("sb0_drained", sb0.size(), 32'd0);
        check("sb1_drained", sb1.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/arm_mem_multiport.md
Name: arm_mem_multiport

Overview:
- Parametrised N-port, word-organised memory for the ARM core.
- Two address-decoded regions: data and text. Base and size are parameters.
- Synchronous reads, byte-enable writes, per-port valid/response handshake.
- Registered, cause-coded exception reporting per port.
- Sits between the fetch/LSU ports and on-chip storage. Successor to the fixed two-port flat memory.

Parameters:
- NPORTS, 2, number of independent request ports (1..4).
- DATA_BASE, 32'h0000_0000, byte base address of data region.
- DATA_WORDS, 256, data region depth in 32-bit words (power of two).
- TEXT_BASE, 32'h0010_0000, byte base address of text region.
- TEXT_WORDS, 256, text region depth in words (power of two).
- TEXT_RO, 1, 1 = writes to text region fault; 0 = text is writable.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NPORTS  per-port request strobe.
- req_write  in  NPORTS  1 = write, 0 = read.
- req_addr  in  32*NPORTS  byte address; port p uses bits [32p+31:32p].
- req_be  in  4*NPORTS  byte enables; be[3] selects bits [31:24] (byte offset 0, big-endian).
- req_wdata  in  32*NPORTS  write data.
- rsp_valid  out  NPORTS  response strobe, one cycle after the accepted request.
- rsp_rdata  out  32*NPORTS  read data; zero for writes and faults.
- rsp_excpt  out  NPORTS  fault on this response.
- rsp_cause  out  2*NPORTS  0 none, 1 unmapped, 2 misaligned, 3 write to RO text.
- excpt_sticky  out  1  OR of all faults since reset or the last clear.
- excpt_clr  in  1  clears excpt_sticky.

Behaviour:
- Reset (rst low, async): rsp_valid=0, rsp_rdata=0, rsp_excpt=0, rsp_cause=0, excpt_sticky=0. Storage contents are not reset.
- Every port accepts a request every cycle; there is no backpressure.
- Latency is exactly 1 cycle: a request at edge N produces rsp_* valid after edge N+1 for one cycle.
- Decode: hit_data = addr in [DATA_BASE, DATA_BASE+4*DATA_WORDS); hit_text is the same form for text.
- Word index = (addr-base)>>2. Computed at 32 bits, no wrap; an address at base+size is unmapped.
- Fault priority: misaligned (addr[1:0]!=0) > unmapped > RO text write.
- A faulting request performs no storage access, returns rdata=0, and sets excpt_sticky.
- Reads are read-first: a same-cycle write to the same word by any port is not visible until the next cycle.
- Writes update only bytes whose be bit is set. be=0 is a legal no-op write: response valid, no fault.
- Multi-port same-word, same-byte write in one cycle: the lowest port index wins for that byte. Other bytes merge.
- A read with any be value returns the full word.
- excpt_clr and a new fault in the same cycle: sticky stays 1 (set wins).
- Reset asserted mid-request: the in-flight response is dropped. Writes in the reset cycle are not guaranteed.
- Regions must not overlap. Elaboration fails if DATA_WORDS or TEXT_WORDS is not a power of two, or if the regions overlap.

Decomposition:
- Package arm_mem_pkg holds the cause encodings (CAUSE_NONE/UNMAPPED/MISALIGN/RO) and the helper function for the region hit test.
- One sub-module, arm_mem_region: a single storage array with NPORTS byte-enable write lanes (priority merge) and NPORTS registered read lanes.
- The top level instantiates arm_mem_region twice and owns decode, fault logic and response registers.

Test Plan:
- Port0 writes 32'hDEADBEEF to 0x10 with be=4'hF, then reads 0x10 -> rsp_valid one cycle later, rdata=32'hDEADBEEF, excpt=0.
- Byte-lane merge: write 32'h11223344 to 0x20 with be=4'hF, then 32'hAABBCCDD with be=4'b0101, then read -> 32'h11BB33DD.
- Collision: port0 writes 32'h0 and port1 writes 32'hFFFFFFFF to 0x40 in the same cycle, both be=4'hF; next cycle read -> 32'h00000000.
- Read-first: port1 reads 0x40 in the same cycle port0 writes 32'h5 there -> port1 gets the old value; the following read returns 32'h5.
- Faults: read of 0x3 -> cause=2; read of 0x400 (DATA_WORDS=256) -> cause=1; write to 0x0010_0000 with TEXT_RO=1 -> cause=3, text unchanged. excpt_sticky=1 in all cases; clears on excpt_clr.
- Async reset: drop rst mid-stream between clock edges -> rsp_valid and excpt_sticky go 0 immediately; previously written data is still readable after reset.
